// File: rtl/freq_mon.sv
// freq_mon: frequency monitor for the 6C tag front end.
//
// Counts TCLK cycles across a window of 2^WIN_LOG2 rising edges of the
// asynchronous reference ECLK. When the window closes, the module reports the
// count on TVAL and pulses TDONE. It also raises the range flags and the
// saturation flag. It supports single-shot and back-to-back continuous
// measurement.
//
// Optional feature macro: FMON_AVG_EN. When defined, the reported TVAL is the
// two-window running average (previous raw + current raw) >> 1.
//
// Ports:
//   TCLK    in   sole clock, rising edge
//   RST     in   asynchronous active-high reset
//   ECLK    in   asynchronous reference, synchronised internally
//   START   in   one-cycle request to begin a measurement (ignored while busy)
//   MODE    in   0 single-shot, 1 continuous; captured on accepted START
//   STOP    in   abort to IDLE, no report; has priority over everything
//   THR_LO  in   [WIDTH] lower bound, TLOW = TVAL < THR_LO
//   THR_HI  in   [WIDTH] upper bound, THIGH = TVAL > THR_HI
//   TVAL    out  [WIDTH] last reported count
//   TDONE   out  one-cycle strobe; TVAL and flags updated this cycle
//   TBUSY   out  high while armed or counting
//   TOVF    out  last window saturated
//   TLOW    out  reported value below THR_LO
//   THIGH   out  reported value above THR_HI
module freq_mon #(
  parameter int WIDTH       = 16,
  parameter int WIN_LOG2    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             TCLK,
  input  logic             RST,
  input  logic             ECLK,
  input  logic             START,
  input  logic             MODE,
  input  logic             STOP,
  input  logic [WIDTH-1:0] THR_LO,
  input  logic [WIDTH-1:0] THR_HI,
  output logic [WIDTH-1:0] TVAL,
  output logic             TDONE,
  output logic             TBUSY,
  output logic             TOVF,
  output logic             TLOW,
  output logic             THIGH
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT} state_t;

  localparam logic [WIDTH-1:0]    CNT_MAX   = '1;
  localparam logic [WIDTH-1:0]    CNT_ONE   = 1;
  localparam logic [WIN_LOG2-1:0] ECNT_LAST = '1;
  localparam logic [WIN_LOG2-1:0] ECNT_ONE  = 1;

  state_t                state, state_nxt;
  logic                  mode_q;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                  eclk_p1;
  logic                  tick;
  logic [WIDTH-1:0]      cnt;
  logic [WIN_LOG2-1:0]   ecnt;
  logic [WIDTH-1:0]      cnt_inc;
  logic                  closing;
  logic                  sat_hit;
  logic                  start_acc;
  logic [WIDTH-1:0]      rep_val;

  // Saturated windows always report the full-scale value.
  function automatic logic [WIDTH-1:0] sat_value();
    return CNT_MAX;
  endfunction

`ifdef FMON_AVG_EN
  // Mean of two samples, computed one bit wider so the sum cannot wrap.
  function automatic logic [WIDTH-1:0] avg2(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  logic [WIDTH-1:0] hist;
  logic             hist_vld;
`endif

  // ---- stage p0/p1: ECLK synchroniser and rising-edge detect ----
  always_ff @(posedge TCLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= '0;
      eclk_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], ECLK};
      eclk_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign tick      = sync_p0[SYNC_STAGES-1] & ~eclk_p1;
  assign cnt_inc   = cnt + CNT_ONE;
  assign closing   = (state == S_COUNT) && tick && (ecnt == ECNT_LAST);
  // A closing tick that lands on the last count wins over saturation.
  assign sat_hit   = (state == S_COUNT) && !closing && (cnt_inc == CNT_MAX);
  assign start_acc = (state == S_IDLE) && START && !STOP;

`ifdef FMON_AVG_EN
  assign rep_val = sat_hit ? sat_value() : (hist_vld ? avg2(hist, cnt_inc) : cnt_inc);
`else
  assign rep_val = sat_hit ? sat_value() : cnt_inc;
`endif

  // ---- control FSM: state register ----
  always_ff @(posedge TCLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---- control FSM: next state ----
  always_comb begin
    state_nxt = state;
    if (STOP) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (START) state_nxt = S_ARM;
        S_ARM:   if (tick)  state_nxt = S_COUNT;
        S_COUNT: begin
          // A continuous window chains straight into the next one. A saturated
          // window has no closing tick to reuse, so it re-arms instead.
          if (closing)      state_nxt = mode_q ? S_COUNT : S_IDLE;
          else if (sat_hit) state_nxt = mode_q ? S_ARM   : S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---- control FSM: outputs ----
  always_comb begin
    TBUSY = (state != S_IDLE);
  end

  // ---- stage p1: window counters ----
  always_ff @(posedge TCLK or posedge RST) begin
    if (RST) begin
      mode_q <= 1'b0;
      cnt    <= '0;
      ecnt   <= '0;
    end else begin
      if (start_acc) mode_q <= MODE;
      if ((state == S_ARM && tick) || closing) begin
        cnt  <= '0;
        ecnt <= '0;
      end else if (state == S_COUNT) begin
        cnt <= cnt_inc;
        if (tick) ecnt <= ecnt + ECNT_ONE;
      end
    end
  end

  // ---- stage p2: reported result and flags ----
  always_ff @(posedge TCLK or posedge RST) begin
    if (RST) begin
      TVAL  <= '0;
      TDONE <= 1'b0;
      TOVF  <= 1'b0;
      TLOW  <= 1'b0;
      THIGH <= 1'b0;
    end else begin
      TDONE <= 1'b0;
      if (!STOP && (closing || sat_hit)) begin
        TDONE <= 1'b1;
        TVAL  <= rep_val;
        TOVF  <= sat_hit;
        TLOW  <= (rep_val < THR_LO);
        THIGH <= (rep_val > THR_HI);
      end
    end
  end

`ifdef FMON_AVG_EN
  // Averaging history: cleared on a new START and after saturation.
  always_ff @(posedge TCLK or posedge RST) begin
    if (RST) begin
      hist     <= '0;
      hist_vld <= 1'b0;
    end else if (start_acc) begin
      hist_vld <= 1'b0;
    end else if (!STOP && closing) begin
      hist     <= cnt_inc;
      hist_vld <= 1'b1;
    end else if (!STOP && sat_hit) begin
      hist_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_freq_mon.sv
module tb_freq_mon;

  logic        TCLK = 1'b0;
  logic        RST;
  // Main instance: WIDTH=16, WIN_LOG2=2
  logic        ECLK, START, MODE, STOP;
  logic [15:0] THR_LO, THR_HI, TVAL;
  logic        TDONE, TBUSY, TOVF, TLOW, THIGH;
  // Saturation instance: WIDTH=8, WIN_LOG2=4
  logic        ECLK2, START2, MODE2, STOP2;
  logic [7:0]  THR_LO2, THR_HI2, TVAL2;
  logic        TDONE2, TBUSY2, TOVF2, TLOW2, THIGH2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int eclk_period = 0;

  always #5 TCLK = ~TCLK;
  always @(posedge TCLK) cyc <= cyc + 1;

  freq_mon #(.WIDTH(16), .WIN_LOG2(2), .SYNC_STAGES(2)) u_dut (
    .TCLK(TCLK), .RST(RST), .ECLK(ECLK), .START(START), .MODE(MODE), .STOP(STOP),
    .THR_LO(THR_LO), .THR_HI(THR_HI), .TVAL(TVAL), .TDONE(TDONE), .TBUSY(TBUSY),
    .TOVF(TOVF), .TLOW(TLOW), .THIGH(THIGH)
  );

  freq_mon #(.WIDTH(8), .WIN_LOG2(4), .SYNC_STAGES(3)) u_sat (
    .TCLK(TCLK), .RST(RST), .ECLK(ECLK2), .START(START2), .MODE(MODE2), .STOP(STOP2),
    .THR_LO(THR_LO2), .THR_HI(THR_HI2), .TVAL(TVAL2), .TDONE(TDONE2), .TBUSY(TBUSY2),
    .TOVF(TOVF2), .TLOW(TLOW2), .THIGH(THIGH2)
  );

  // Reference clock generator for the main instance: a new period takes
  // effect at the next rising edge; period 0 holds ECLK low.
  initial begin
    int p;
    ECLK = 1'b0;
    forever begin
      if (eclk_period == 0) begin
        ECLK = 1'b0;
        @(negedge TCLK);
      end else begin
        p = eclk_period;
        ECLK = 1'b1;
        repeat (p / 2) @(negedge TCLK);
        ECLK = 1'b0;
        repeat (p - p / 2) @(negedge TCLK);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(input int which, input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge TCLK);
      if ((which == 0) ? TDONE : TDONE2) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic watch_quiet(input int which, input int n, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge TCLK);
      if ((which == 0) ? TDONE : TDONE2) seen = 1'b1;
    end
    chk(name, seen, 1'b0);
  endtask

  // Model: with a steady reference period p, a window of 2^WIN_LOG2 edges
  // spans exactly 2^WIN_LOG2 * p TCLK cycles.
  task automatic measure(input string name, input int period, input int lo, input int hi);
    bit got;
    int exp_v;
    exp_v = 4 * period;
    eclk_period = period;
    THR_LO = 16'(lo);
    THR_HI = 16'(hi);
    repeat (48) @(negedge TCLK);
    MODE = 1'b0; START = 1'b1;
    @(negedge TCLK);
    START = 1'b0;
    chk({name, "_busy"}, TBUSY, 1'b1);
    wait_done(0, 4 * period + 200, got);
    chk({name, "_done"}, got, 1'b1);
    chk({name, "_tval"}, TVAL, exp_v);
    chk({name, "_low"}, TLOW, (exp_v < lo));
    chk({name, "_high"}, THIGH, (exp_v > hi));
    chk({name, "_ovf"}, TOVF, 1'b0);
    chk({name, "_idle"}, TBUSY, 1'b0);
  endtask

  typedef struct {
    int period;
    int lo;
    int hi;
    int exp_tval;
    bit exp_low;
    bit exp_high;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit got;
    int t_prev;
    vecs[0] = '{8,  0,  100, 32, 1'b0, 1'b0};
    vecs[1] = '{5,  21, 19,  20, 1'b1, 1'b1};
    vecs[2] = '{10, 40, 40,  40, 1'b0, 1'b0};
    vecs[3] = '{8,  33, 40,  32, 1'b1, 1'b0};
    vecs[4] = '{12, 33, 40,  48, 1'b0, 1'b1};

    RST = 1'b1; START = 0; MODE = 0; STOP = 0; THR_LO = 0; THR_HI = 16'hFFFF;
    ECLK2 = 0; START2 = 0; MODE2 = 0; STOP2 = 0; THR_LO2 = 0; THR_HI2 = 8'd200;
    repeat (3) @(negedge TCLK);
    chk("rst_tval", TVAL, 0);
    chk("rst_tdone", TDONE, 0);
    chk("rst_tbusy", TBUSY, 0);
    chk("rst_flags", {TOVF, TLOW, THIGH}, 0);
    RST = 1'b0;
    @(negedge TCLK);

    // Single-shot vectors
    for (int i = 0; i < 5; i++) begin
      eclk_period = vecs[i].period;
      THR_LO = 16'(vecs[i].lo);
      THR_HI = 16'(vecs[i].hi);
      repeat (48) @(negedge TCLK);
      MODE = 1'b0; START = 1'b1;
      @(negedge TCLK);
      START = 1'b0;
      chk("vec_busy", TBUSY, 1'b1);
      wait_done(0, 400, got);
      chk("vec_done", got, 1'b1);
      chk("vec_tval", TVAL, vecs[i].exp_tval);
      chk("vec_low", TLOW, vecs[i].exp_low);
      chk("vec_high", THIGH, vecs[i].exp_high);
      chk("vec_ovf", TOVF, 1'b0);
      chk("vec_idle", TBUSY, 1'b0);
      watch_quiet(0, 60, "vec_single_no_more_done");
    end

    // Continuous: three windows of period 8, then switch to period 10
    eclk_period = 8; THR_LO = 0; THR_HI = 16'hFFFF;
    repeat (48) @(negedge TCLK);
    MODE = 1'b1; START = 1'b1;
    @(negedge TCLK);
    START = 1'b0; MODE = 1'b0;
    t_prev = 0;
    for (int w = 0; w < 3; w++) begin
      wait_done(0, 200, got);
      chk("cont_done", got, 1'b1);
      chk("cont_tval", TVAL, 32);
      chk("cont_busy", TBUSY, 1'b1);
      if (w > 0) chk("cont_spacing", cyc - t_prev, 32);
      t_prev = cyc;
    end
    eclk_period = 10;
    wait_done(0, 200, got);
    chk("cont_mixed_done", got, 1'b1);
    wait_done(0, 200, got);
    chk("cont_p10_done", got, 1'b1);
    chk("cont_p10_tval", TVAL, 40);
    STOP = 1'b1;
    @(negedge TCLK);
    STOP = 1'b0;
    chk("cont_stop_idle", TBUSY, 1'b0);
    chk("cont_stop_tval", TVAL, 40);
    watch_quiet(0, 80, "cont_stop_quiet");

    // START and STOP in the same cycle: STOP wins
    START = 1'b1; STOP = 1'b1;
    @(negedge TCLK);
    START = 1'b0; STOP = 1'b0;
    chk("startstop_idle", TBUSY, 1'b0);
    watch_quiet(0, 80, "startstop_quiet");

    // Randomised single-shot measurements against the model
    for (int r = 0; r < 8; r++) begin
      measure("rand", $urandom_range(40, 5), $urandom_range(200, 0), $urandom_range(200, 0));
    end

    // Known value before the abort tests
    measure("pre_stop", 12, 33, 40);

    // STOP mid-count: no report, previous value retained
    eclk_period = 20;
    repeat (48) @(negedge TCLK);
    START = 1'b1;
    @(negedge TCLK);
    START = 1'b0;
    repeat (40) @(negedge TCLK);
    chk("midstop_busy", TBUSY, 1'b1);
    STOP = 1'b1;
    @(negedge TCLK);
    STOP = 1'b0;
    chk("midstop_idle", TBUSY, 1'b0);
    watch_quiet(0, 120, "midstop_quiet");
    chk("midstop_tval", TVAL, 48);
    chk("midstop_flags", {TLOW, THIGH}, 2'b01);

    // Saturation, single-shot: opening tick then no more reference edges
    START2 = 1'b1; MODE2 = 1'b0;
    @(negedge TCLK);
    START2 = 1'b0;
    chk("sat_busy", TBUSY2, 1'b1);
    ECLK2 = 1'b1;
    repeat (3) @(negedge TCLK);
    ECLK2 = 1'b0;
    wait_done(1, 400, got);
    chk("sat_done", got, 1'b1);
    chk("sat_tval", TVAL2, 255);
    chk("sat_ovf", TOVF2, 1'b1);
    chk("sat_high", THIGH2, 1'b1);
    chk("sat_idle", TBUSY2, 1'b0);

    // Saturation, continuous: re-arms and stays busy
    START2 = 1'b1; MODE2 = 1'b1;
    @(negedge TCLK);
    START2 = 1'b0;
    ECLK2 = 1'b1;
    repeat (3) @(negedge TCLK);
    ECLK2 = 1'b0;
    wait_done(1, 400, got);
    chk("sat_cont_done", got, 1'b1);
    chk("sat_cont_tval", TVAL2, 255);
    chk("sat_cont_ovf", TOVF2, 1'b1);
    @(negedge TCLK);
    chk("sat_cont_rearm", TBUSY2, 1'b1);
    watch_quiet(1, 300, "sat_cont_arm_waits");
    STOP2 = 1'b1;
    @(negedge TCLK);
    STOP2 = 1'b0;
    chk("sat_cont_stop", TBUSY2, 1'b0);

    // Reset mid-window: everything back to zero, no report
    eclk_period = 20;
    repeat (48) @(negedge TCLK);
    START = 1'b1;
    @(negedge TCLK);
    START = 1'b0;
    repeat (40) @(negedge TCLK);
    RST = 1'b1;
    #1;
    chk("midrst_tval", TVAL, 0);
    chk("midrst_busy", TBUSY, 0);
    chk("midrst_flags", {TOVF, TLOW, THIGH}, 0);
    chk("midrst_sat_tval", TVAL2, 0);
    @(negedge TCLK);
    RST = 1'b0;
    watch_quiet(0, 120, "midrst_quiet");
    chk("midrst_idle", TBUSY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
